// File: rtl/copy_read_engine.sv
// Copy command executor: reads the 16-bank history window once, expands the copied bytes
// (including overlapping-offset replication) and re-emits them as write tokens of up to 16 bytes.
module copy_read_engine #(
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [143:0]   cmd_address,
    input  logic [15:0]    cmd_ram_select,
    input  logic [127:0]   cmd_rd,
    input  logic [15:0]    cmd_offset,
    input  logic [15:0]    cmd_dst,
    output logic [15:0]    rd_en,
    output logic [143:0]   rd_addr,
    input  logic [1023:0]  rd_data,
    output logic [127:0]   wr_data,
    output logic [3:0]     wr_length,
    output logic [15:0]    wr_address,
    output logic           wr_valid,
    input  logic           wr_ready,
    output logic           err
);

    typedef enum logic [1:0] {StIdle, StRead, StWait, StEmit} state_e;

    state_e       state_q, state_d;
    logic [5:0]   len_q;
    logic [15:0]  off_q;
    logic [15:0]  dst_q;
    logic [1:0]   cnt_q;
    logic [1:0]   beat_q;
    logic [511:0] pat_q;

    logic [7:0]   pop;
    logic         cmd_ok;
    logic         accept;
    logic         wait_last;
    logic         hs;
    logic         last_beat;
    logic [1:0]   nxt_beat;
    logic [6:0]   s;
    logic [6:0]   period;
    logic [511:0] pat_d;

    always_comb begin
        pop = '0;
        for (int b = 0; b < 128; b++) begin
            pop = pop + 8'(cmd_rd[b]);
        end
    end

    assign cmd_ok    = (cmd_rd != '0) && (cmd_offset != '0);
    assign accept    = cmd_valid && (state_q == StIdle);
    assign wait_last = (cnt_q == 2'(RD_LATENCY - 1));
    assign hs        = wr_valid && wr_ready;
    assign last_beat = (beat_q == len_q[5:4]);
    assign nxt_beat  = beat_q + 2'd1;

    // Source start within the 128-byte window; only the low 7 bits of dst - offset matter.
    assign s = dst_q[6:0] - off_q[6:0];

    // Repeat period of the copied pattern; offsets >= 64 never overlap a <=64-byte copy.
    always_comb begin
        if (off_q >= 16'd64) begin
            period = 7'd64;
        end else if (off_q == '0) begin
            period = 7'd1;
        end else begin
            period = off_q[6:0];
        end
    end

    // Byte j of the copy is window byte s + (j mod offset): this is the overlap replication.
    always_comb begin
        pat_d = '0;
        for (int j = 0; j < 64; j++) begin
            if (6'(j) <= len_q) begin
                int idx;
                idx = (int'(s) + (j % int'(period))) % 128;
                pat_d[511-8*j -: 8] = rd_data[64*(idx/8) + 63 - 8*(idx%8) -: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept && cmd_ok) state_d = StRead;
            StRead: state_d = StWait;
            StWait: if (wait_last) state_d = StEmit;
            StEmit: if (hs && last_beat) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q      <= '0;
            off_q      <= '0;
            dst_q      <= '0;
            cnt_q      <= '0;
            beat_q     <= '0;
            pat_q      <= '0;
            rd_en      <= '0;
            rd_addr    <= '0;
            wr_data    <= '0;
            wr_length  <= '0;
            wr_address <= '0;
            wr_valid   <= 1'b0;
            err        <= 1'b0;
        end else begin
            err   <= 1'b0;
            rd_en <= '0;
            if (accept) begin
                len_q <= 6'(pop - 8'd1);
                off_q <= cmd_offset;
                dst_q <= cmd_dst;
                if (cmd_ok) begin
                    rd_en   <= cmd_ram_select;
                    rd_addr <= cmd_address;
                end else begin
                    err <= 1'b1;
                end
            end
            if (state_q == StRead) begin
                cnt_q <= '0;
            end
            if (state_q == StWait) begin
                cnt_q <= cnt_q + 2'd1;
                if (wait_last) begin
                    pat_q      <= pat_d;
                    wr_valid   <= 1'b1;
                    wr_data    <= pat_d[511 -: 128];
                    wr_length  <= (len_q[5:4] != 2'd0) ? 4'hF : len_q[3:0];
                    wr_address <= dst_q;
                    beat_q     <= '0;
                end
            end
            if (state_q == StEmit && hs) begin
                if (last_beat) begin
                    wr_valid <= 1'b0;
                end else begin
                    beat_q     <= nxt_beat;
                    wr_data    <= pat_q[511 - 128*int'(nxt_beat) -: 128];
                    wr_length  <= (nxt_beat < len_q[5:4]) ? 4'hF : len_q[3:0];
                    wr_address <= wr_address + 16'd16;
                end
            end
        end
    end

endmodule

// File: tb/tb_copy_read_engine.sv
// Randomized and directed bench for copy_read_engine against a byte-level copy model.
module tb_copy_read_engine;

    localparam int unsigned RL = 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [143:0]   cmd_address;
    logic [15:0]    cmd_ram_select;
    logic [127:0]   cmd_rd;
    logic [15:0]    cmd_offset;
    logic [15:0]    cmd_dst;
    logic [15:0]    rd_en;
    logic [143:0]   rd_addr;
    logic [1023:0]  rd_data;
    logic [127:0]   wr_data;
    logic [3:0]     wr_length;
    logic [15:0]    wr_address;
    logic           wr_valid;
    logic           wr_ready;
    logic           err;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]   mem [16][512][8];
    logic [127:0] exp_data [4];
    logic [3:0]   exp_len  [4];
    logic [15:0]  exp_addr [4];
    logic [127:0] obs_data [4];
    int           exp_nb;

    copy_read_engine #(.RD_LATENCY(RL)) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_address    (cmd_address),
        .cmd_ram_select (cmd_ram_select),
        .cmd_rd         (cmd_rd),
        .cmd_offset     (cmd_offset),
        .cmd_dst        (cmd_dst),
        .rd_en          (rd_en),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .wr_data        (wr_data),
        .wr_length      (wr_length),
        .wr_address     (wr_address),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .err            (err)
    );

    always #5 clk = ~clk;

    // Single-cycle BRAM banks; each bank holds its last read word.
    always @(posedge clk) begin
        for (int i = 0; i < 16; i++) begin
            if (rd_en[i]) begin
                for (int k = 0; k < 8; k++) begin
                    rd_data[64*i+63-8*k -: 8] <= mem[i][rd_addr[9*i +: 9]][k];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic build_expected(input logic [143:0] addr, input logic [127:0] rdm,
                                  input logic [15:0] off, input logic [15:0] dst);
        logic [7:0]  win [128];
        logic [7:0]  outb [64];
        logic [15:0] src;
        int          cnt;
        int          last;
        cnt = 0;
        for (int b = 0; b < 128; b++) cnt += int'(rdm[b]);
        last = cnt - 1;
        for (int b = 0; b < 128; b++) win[b] = mem[b/8][addr[9*(b/8) +: 9]][b%8];
        src = dst - off;
        for (int j = 0; j <= last; j++) begin
            if (j < int'(off)) outb[j] = win[(int'(src[6:0]) + j) % 128];
            else               outb[j] = outb[j - int'(off)];
        end
        exp_nb = last / 16 + 1;
        for (int n = 0; n < exp_nb; n++) begin
            exp_data[n] = '0;
            for (int m = 0; m < 16; m++) begin
                if (16*n + m <= last) exp_data[n][127-8*m -: 8] = outb[16*n+m];
            end
            exp_len[n]  = (last - 16*n > 15) ? 4'hF : 4'(last - 16*n);
            exp_addr[n] = dst + 16'(16*n);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " cmd_ready"}, cmd_ready, 1);
        check({tag, " rd_en"}, rd_en, 0);
        check({tag, " rd_addr"}, rd_addr[127:0], 0);
        check({tag, " wr_valid"}, wr_valid, 0);
        check({tag, " wr_data"}, wr_data, 0);
        check({tag, " wr_len_addr"}, {wr_length, wr_address}, 0);
        check({tag, " err"}, err, 0);
    endtask

    // bp: stall percentage; stall_beat gets exactly 3 stall cycles; rst_beat resets on that beat.
    task automatic run_cmd(input logic [143:0] addr, input logic [127:0] rdm,
                           input logic [15:0] off, input logic [15:0] dst,
                           input int bp, input int stall_beat, input int rst_beat);
        int cyc;
        int n;
        int guard;
        int stalls;
        logic rdy;
        @(negedge clk);
        check("cmd_ready idle", cmd_ready, 1);
        cmd_address    = addr;
        cmd_ram_select = 16'hFFFF;
        cmd_rd         = rdm;
        cmd_offset     = off;
        cmd_dst        = dst;
        cmd_valid      = 1'b1;
        wr_ready       = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        if (rdm == '0 || off == '0) begin
            check("err pulse", err, 1);
            check("no rd_en on err", rd_en, 0);
            @(negedge clk);
            check("err one cycle", err, 0);
            check("no wr_valid on err", wr_valid, 0);
            check("cmd_ready after err", cmd_ready, 1);
            return;
        end
        check("rd_en at T+1", rd_en, 16'hFFFF);
        check("cmd_ready busy", cmd_ready, 0);
        build_expected(addr, rdm, off, dst);
        cyc = 1;
        while (!wr_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("first wr_valid latency", cyc, RL + 2);
        n = 0;
        guard = 0;
        stalls = 0;
        while (n < exp_nb && guard < 300) begin
            guard++;
            check("wr_valid held", wr_valid, 1);
            check("wr_data", wr_data, exp_data[n]);
            check("wr_length", wr_length, exp_len[n]);
            check("wr_address", wr_address, exp_addr[n]);
            check("cmd_ready in emit", cmd_ready, 0);
            if (n == rst_beat) begin
                rst = 1'b1;
                #1;
                check_reset_outputs("async reset");
                @(negedge clk);
                rst = 1'b0;
                cmd_valid = 1'b0;
                wr_ready = 1'b1;
                for (int c = 0; c < 4; c++) begin
                    @(negedge clk);
                    check("no beat after reset", wr_valid, 0);
                    check("cmd_ready after reset", cmd_ready, 1);
                end
                wr_ready = 1'b0;
                return;
            end
            if (n == stall_beat && stalls < 3) begin
                rdy = 1'b0;
                stalls++;
            end else begin
                rdy = ($urandom_range(99) >= bp);
            end
            wr_ready  = rdy;
            cmd_valid = !rdy && ($urandom_range(1) == 1);
            @(negedge clk);
            if (rdy) begin
                obs_data[n] = wr_data;
                n++;
            end else begin
                obs_data[n] = wr_data;
            end
        end
        if (guard >= 300) check("beat loop timeout", 0, 1);
        cmd_valid = 1'b0;
        wr_ready  = 1'b0;
        check("wr_valid after last", wr_valid, 0);
        check("cmd_ready after last", cmd_ready, 1);
    endtask

    function automatic logic [127:0] mask_n(input int cnt);
        logic [127:0] all;
        all = '1;
        return (cnt == 0) ? '0 : all >> (128 - cnt);
    endfunction

    initial begin
        #2000000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [143:0] a5;
        logic [143:0] ra;
        logic [15:0]  off;
        a5 = {16{9'd5}};
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_address = '0;
        cmd_ram_select = '0;
        cmd_rd = '0;
        cmd_offset = '0;
        cmd_dst = '0;
        wr_ready = 1'b0;
        rd_data = '0;
        for (int i = 0; i < 16; i++)
            for (int a = 0; a < 512; a++)
                for (int k = 0; k < 8; k++) mem[i][a][k] = 8'($urandom);
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Single-beat copy: window bytes 64..71 = bank 8.
        for (int k = 0; k < 8; k++) mem[8][5][k] = 8'(k + 1);
        run_cmd(a5, mask_n(8), 16'h0040, 16'h0100, 0, -1, -1);
        check("single beat data", obs_data[0], {64'h0102030405060708, 64'h0});

        // Multi-beat, with and without backpressure on beat 1.
        run_cmd(a5, mask_n(40), 16'd64, 16'h0200, 0, -1, -1);
        run_cmd(a5, mask_n(40), 16'd64, 16'h0200, 0, 1, -1);

        // Overlap.
        mem[0][5][0] = 8'hAB;
        run_cmd(a5, mask_n(10), 16'd1, 16'h0301, 0, -1, -1);
        check("overlap a data", obs_data[0], {{10{8'hAB}}, 48'h0});
        mem[0][5][0] = 8'h11;
        mem[0][5][1] = 8'h22;
        mem[0][5][2] = 8'h33;
        run_cmd(a5, mask_n(8), 16'd3, 16'h0403, 0, -1, -1);
        check("overlap b data", obs_data[0], {64'h1122331122331122, 64'h0});

        // Window wrap and illegal commands.
        run_cmd(a5, mask_n(8), 16'd64, 16'h00BC, 0, -1, -1);
        run_cmd(a5, mask_n(8), 16'd0, 16'h0100, 0, -1, -1);
        run_cmd(a5, '0, 16'd64, 16'h0100, 0, -1, -1);

        // Reset mid-EMIT, then the single-beat copy again.
        run_cmd(a5, mask_n(40), 16'd64, 16'h0200, 0, -1, 2);
        run_cmd(a5, mask_n(8), 16'h0040, 16'h0100, 0, -1, -1);
        check("post-reset beat data", obs_data[0], {64'h0102030405060708, 64'h0});

        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < 16; i++) ra[9*i +: 9] = 9'($urandom);
            off = ($urandom_range(1) == 1) ? 16'($urandom_range(70, 1))
                                           : 16'($urandom_range(65535, 1));
            run_cmd(ra, mask_n($urandom_range(64, 1)), off, 16'($urandom), 30, -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/copy_read_engine.md
# copy_read_engine

Executes one copy command from the copy parser against the 16-bank history BRAM. It reads the addressed banks and extracts the copied bytes, handling wrap and overlap, then re-emits them as literal-style write tokens (≤16 bytes each) to the literal write path. This block closes the loop between copy-token parsing and BRAM writeback, with one command in flight at a time.

## Interface
- RD_LATENCY, 1, cycles from `rd_en` to valid `rd_data` (legal 1..3)
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- cmd_valid  in  1  copy command present
- cmd_ready  out  1  engine accepts a command (IDLE only)
- cmd_address  in  144  16×9-bit bank addresses; bank i uses [9i+8:9i]
- cmd_ram_select  in  16  banks to read
- cmd_rd  in  128  byte read mask; bit 127-8i-k is bank i, byte k
- cmd_offset  in  16  copy offset in bytes
- cmd_dst  in  16  destination byte address
- rd_en  out  16  per-bank read enable
- rd_addr  out  144  per-bank read address, same packing as `cmd_address`
- rd_data  in  1024  bank i at [64i+63:64i]; byte k at [64i+63-8k -: 8]
- wr_data  out  128  token data; first byte at [127:120]
- wr_length  out  4  token length minus 1
- wr_address  out  16  token destination byte address
- wr_valid  out  1  token valid
- wr_ready  in  1  downstream accepts token
- err  out  1  one-cycle pulse: command dropped

## Operation
- **States:** IDLE, READ, WAIT, EMIT.
- **IDLE.** `cmd_ready`=1. On `cmd_valid`&`cmd_ready`, the engine latches all `cmd_*` fields.
  - L = popcount(`cmd_rd`) − 1. The legal range is 0..63.
  - If `cmd_rd`==0 or `cmd_offset`==0, the engine pulses `err`, produces no output, and stays in IDLE.
  - Otherwise it goes to READ.
- **READ.** One cycle: `rd_en`=latched `ram_select`, `rd_addr`=latched address. Then go to WAIT. `rd_en` is 0 in every other state.
- **WAIT.** Count RD_LATENCY cycles.
  - On the last count, capture `rd_data` into a 1024-bit buffer and go to EMIT.
  - Linear buffer byte index is 8i+k.
- **Byte extraction** for output byte j, 0 ≤ j ≤ L:
  - src = (`cmd_dst` − `cmd_offset`) mod 2^16; s = src[6:0].
  - If j < offset: byte j = buffer[(s+j) mod 128].
  - If j ≥ offset: byte j = output byte (j − offset). This replicates the pattern for overlapping copies, offset < L+1.
- **EMIT.** Beats n = 0..⌈(L+1)/16⌉−1.
  - `wr_data` = bytes 16n..16n+15, with byte 16n at [127:120]. Bytes beyond L are 0.
  - `wr_length` = min(15, L−16n).
  - `wr_address` = (`cmd_dst` + 16n) mod 2^16.
  - The beat advances only on `wr_valid`&`wr_ready`; the token is held stable otherwise.
  - Handshake on the last beat → IDLE.
- `cmd_ready`=0 in READ, WAIT and EMIT. A `cmd_valid` seen in those states is not consumed.
- **Reset (any time, including mid-EMIT):** state → IDLE; the in-flight command is discarded.
  - Reset values: `cmd_ready`=1; `rd_en`=0, `rd_addr`=0; `wr_valid`=0, `wr_data`=0, `wr_length`=0, `wr_address`=0; `err`=0.

## Timing
- **Accept at cycle T:** `rd_en` high at T+1; buffer captured at T+1+RD_LATENCY; first `wr_valid` at T+2+RD_LATENCY.
- With `wr_ready` held 1, beats are back-to-back, one per cycle.
- `cmd_ready` rises the cycle after the last beat handshake.
- Minimum command period with `wr_ready`=1: 3+RD_LATENCY+beats−1 cycles.
- `err` is asserted in cycle T+1, for one cycle.
- All outputs are registered. No combinational path exists from `wr_ready` or `cmd_valid` to any output except `cmd_ready`, which is state-only.

## Test plan
1. **Single-beat copy.** Banks preloaded so bytes 0x00C0..0x00C7 = 01..08; command dst=0x0100, offset=0x0040, 8-byte mask.
   - Required: `rd_en` at T+1; one beat at T+3 (RD_LATENCY=1) with address 0x0100, length 7, `wr_data`=0x0102030405060708_0000000000000000.
2. **Multi-beat copy.** 40-byte copy, offset 64, dst=0x0200.
   - Required: three beats; lengths 15, 15, 7; addresses 0x0200, 0x0210, 0x0220; data matches source bytes in order.
3. **Overlap.** Case a: offset 1, L=9, source byte 0xAB. Case b: offset 3, L=7, source 11 22 33.
   - Required: case a emits 10×0xAB. Case b emits 11 22 33 11 22 33 11 22, zero-filled.
4. **Backpressure.** `wr_ready`=0 for 3 cycles during beat 1 of scenario 2.
   - Required: beat 1 held unchanged; no beat skipped or duplicated; `cmd_ready` stays 0; a concurrent `cmd_valid` is not accepted.
5. **Window wrap and illegal commands.** Case a: s=0x7C, L=7. Case b: offset 0. Case c: `cmd_rd`=0.
   - Required: case a takes bytes 124..127 (bank 15) then 0..3 (bank 0), in that order. Cases b and c: `err` pulses at T+1, no `rd_en`, no `wr_valid`.
6. **Reset mid-EMIT.** Assert `rst` during beat 2 of scenario 2.
   - Required: all outputs go to their reset values asynchronously; after release, `cmd_ready`=1; no further beats; the next command behaves as in scenario 1.
